seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/bcd_seg_decode.sv | 25 ++
 rtl/seg7_scan_driver.sv | 112 +++++++++++
 tb/tb_seg7_scan_driver.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment codes (a..g on bits 0..6)
// and the default per-digit refresh period.
package seg7_pkg;

  localparam int unsigned REFRESH_DIV_DEFAULT = 2500;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD nibble to 7-segment pattern; non-decimal nibbles show blank.
module bcd_seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver with frame-synchronous value updates,
// per-digit dead time and optional leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV   = REFRESH_DIV_DEFAULT,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_bcd,
  input  logic [3:0]  load_dp,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  digit_en,
  output logic        frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       digit_idx;
  logic [15:0]      active_bcd;
  logic [3:0]       active_dp;
  logic [15:0]      pend_bcd;
  logic [3:0]       pend_dp;
  logic             pend_vld;

  logic             wrap;
  logic             boundary;
  logic             accept;
  logic [3:0]       cur_nib;
  logic [6:0]       dec_seg;
  logic [3:0]       lead_blank;

  assign wrap       = (refresh_cnt == CNT_LAST);
  assign boundary   = wrap && (digit_idx == 2'd3);
  assign load_ready = !pend_vld;
  assign accept     = load_valid && load_ready && !reset;

  // Stage 0: scan counters, pending/active value hand-off at frame boundaries.
  // A value accepted on the boundary edge sees pend_vld low, so it waits a full frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      active_bcd  <= 16'h0000;
      active_dp   <= 4'b0000;
      pend_vld    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (wrap) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + CNT_W'(1);
      end
      if (boundary && pend_vld) begin
        active_bcd <= pend_bcd;
        active_dp  <= pend_dp;
        pend_vld   <= 1'b0;
      end else if (accept) begin
        pend_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pend_bcd <= load_bcd;
      pend_dp  <= load_dp;
    end
  end

  assign cur_nib = active_bcd[{digit_idx, 2'b00} +: 4];

  // A digit is leading-blank when it and all higher digits are zero; digit 0 never is.
  always_comb begin
    lead_blank    = 4'b0000;
    lead_blank[3] = BLANK_LEADING && (active_bcd[15:12] == 4'd0);
    lead_blank[2] = lead_blank[3] && (active_bcd[11:8] == 4'd0);
    lead_blank[1] = lead_blank[2] && (active_bcd[7:4] == 4'd0);
  end

  bcd_seg_decode u_dec (
    .bcd (cur_nib),
    .seg (dec_seg)
  );

  // Stage 1: registered display outputs, dead time on refresh count 0 of each digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg      <= SEG_BLANK;
      dp       <= 1'b0;
      digit_en <= 4'b0000;
    end else begin
      seg <= lead_blank[digit_idx] ? SEG_BLANK : dec_seg;
      if (refresh_cnt == '0) begin
        digit_en <= 4'b0000;
        dp       <= 1'b0;
      end else begin
        digit_en <= onehot4(digit_idx);
        dp       <= active_dp[digit_idx];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus queues expected frames tagged by
// frame number, a negedge monitor checks every output cycle of tagged frames.
module tb_seg7_scan_driver;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [15:0] load_bcd;
  logic [3:0]  load_dp;
  logic        load_ready, load_ready_nb;
  logic [6:0]  seg, seg_nb;
  logic        dp, dp_nb;
  logic [3:0]  digit_en, digit_en_nb;
  logic        frame_done, frame_done_nb;

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_bcd(load_bcd), .load_dp(load_dp), .seg(seg), .dp(dp),
    .digit_en(digit_en), .frame_done(frame_done)
  );

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready_nb),
    .load_bcd(load_bcd), .load_dp(load_dp), .seg(seg_nb), .dp(dp_nb),
    .digit_en(digit_en_nb), .frame_done(frame_done_nb)
  );

  typedef struct {
    int              tag;
    logic [3:0][6:0] seg_bl;
    logic [3:0][6:0] seg_nb;
    logic [3:0]      dp;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   have_exp = 1'b0;
  int   pos = 0;
  int   frames = 0;
  int   vectors = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void push(input int tag, input logic [27:0] bl, input logic [27:0] nb,
                               input logic [3:0] d);
    exp_t e;
    e.tag    = tag;
    e.seg_bl = bl;
    e.seg_nb = nb;
    e.dp     = d;
    exp_q.push_back(e);
  endfunction

  task automatic check_cycle(input int p);
    int k, r;
    logic [3:0] en;
    k  = (p - 1) / RD;
    r  = (p - 1) % RD;
    en = (r == 0) ? 4'b0000 : 4'(1 << k);
    check($sformatf("f%0d_p%0d_digit_en", frames, p), 32'(digit_en), 32'(en));
    check($sformatf("f%0d_p%0d_digit_en_nb", frames, p), 32'(digit_en_nb), 32'(en));
    check($sformatf("f%0d_p%0d_dp", frames, p), 32'(dp), 32'(en != 0 && cur.dp[k]));
    check($sformatf("f%0d_p%0d_dp_nb", frames, p), 32'(dp_nb), 32'(en != 0 && cur.dp[k]));
    if (en != 4'b0000) begin
      check($sformatf("f%0d_p%0d_seg", frames, p), 32'(seg), 32'(cur.seg_bl[k]));
      check($sformatf("f%0d_p%0d_seg_nb", frames, p), 32'(seg_nb), 32'(cur.seg_nb[k]));
    end
  endtask

  // Monitor: frame_done opens frame N; the following 4*RD cycles belong to it.
  always @(negedge clk) begin
    if (reset) begin
      have_exp = 1'b0;
      pos      = 0;
    end else if (frame_done) begin
      if (have_exp) begin
        check($sformatf("f%0d_frame_len", frames), pos, 4 * RD - 1);
        check_cycle(4 * RD);
      end
      frames++;
      have_exp = 1'b0;
      pos      = 0;
      while (exp_q.size() > 0 && exp_q[0].tag < frames) begin
        check("missed_frame", exp_q[0].tag, frames);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].tag == frames) begin
        cur      = exp_q.pop_front();
        have_exp = 1'b1;
      end
    end else begin
      pos++;
      if (have_exp) begin
        if (pos > 4 * RD - 1) begin
          check($sformatf("f%0d_frame_len", frames), pos, 4 * RD - 1);
          have_exp = 1'b0;
        end else begin
          check_cycle(pos);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!frame_done && n < 200);
    if (!frame_done) check("fd_timeout", 32'(frame_done), 32'd1);
  endtask

  task automatic wait_frame(input int tgt);
    int g = 0;
    do begin
      wait_fd();
      g++;
    end while (frames + 1 < tgt && g < 20);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, output int tgt,
                         output logic at_bnd);
    int n = 0;
    load_bcd   = v;
    load_dp    = d;
    load_valid = 1'b1;
    while (!load_ready && n < 200) begin
      tick();
      n++;
    end
    if (!load_ready) check("load_ready_timeout", 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0;
    at_bnd     = frame_done;
    tgt        = frames + 1 + int'(frame_done);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int   t1, t2, t3, n;
    logic bnd;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_bcd   = 16'h0000;
    load_dp    = 4'b0000;
    repeat (3) tick();
    check("rst_seg", 32'(seg), 32'd0);
    check("rst_dp", 32'(dp), 32'd0);
    check("rst_digit_en", 32'(digit_en), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_seg_nb", 32'(seg_nb), 32'd0);
    reset = 1'b0;

    // Value 0000 after reset: only digit 0 lit when blanking.
    push(frames + 1, {7'h00, 7'h00, 7'h00, 7'h3F}, {4{7'h3F}}, 4'b0000);
    wait_fd();

    do_load(16'h1234, 4'b0100, t1, bnd);
    check("ready_low_after_1234", 32'(load_ready), 32'd0);
    push(t1, {7'h06, 7'h5B, 7'h4F, 7'h66}, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100);
    wait_frame(t1);
    check("ready_high_after_apply", 32'(load_ready), 32'd1);
    check("ready_high_after_apply_nb", 32'(load_ready_nb), 32'd1);

    do_load(16'h0050, 4'b0000, t2, bnd);
    push(t2, {7'h00, 7'h00, 7'h6D, 7'h3F}, {7'h3F, 7'h3F, 7'h6D, 7'h3F}, 4'b0000);
    wait_frame(t2);

    // 1111 then 2222 offered back-to-back.
    do_load(16'h1111, 4'b0000, t1, bnd);
    push(t1, {4{7'h06}}, {4{7'h06}}, 4'b0000);
    load_bcd   = 16'h2222;
    load_dp    = 4'b0000;
    load_valid = 1'b1;
    check("ready_low_busy", 32'(load_ready), 32'd0);
    n = 0;
    while (!load_ready && n < 200) begin
      tick();
      n++;
    end
    check("ready_rise_with_fd", 32'(frame_done), 32'd1);
    check("ready_rise_frame", frames + 1, t1);
    tick();
    load_valid = 1'b0;
    t2 = frames + 1 + int'(frame_done);
    check("tgt_2222", t2, t1 + 1);
    push(t2, {4{7'h5B}}, {4{7'h5B}}, 4'b0000);
    wait_frame(t2);

    // 9A0B accepted exactly on a boundary edge: held one extra frame.
    repeat (4 * RD - 1) tick();
    do_load(16'h9A0B, 4'b0000, t3, bnd);
    check("coincident_boundary", 32'(bnd), 32'd1);
    check("coincident_tgt", t3, frames + 2);
    push(t3 - 1, {4{7'h5B}}, {4{7'h5B}}, 4'b0000);
    push(t3, {7'h6F, 7'h00, 7'h3F, 7'h00}, {7'h6F, 7'h00, 7'h3F, 7'h00}, 4'b0000);
    wait_frame(t3 + 1);

    // Reset mid-frame (digit 2) with a value pending.
    repeat (2) tick();
    do_load(16'h1234, 4'b1111, t1, bnd);
    check("pending_before_reset", 32'(load_ready), 32'd0);
    repeat (2 * RD - 2) tick();
    reset      = 1'b1;
    load_valid = 1'b1;
    load_bcd   = 16'h7777;
    tick();
    check("midrst_seg", 32'(seg), 32'd0);
    check("midrst_dp", 32'(dp), 32'd0);
    check("midrst_digit_en", 32'(digit_en), 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    check("midrst_load_ready", 32'(load_ready), 32'd1);
    check("midrst_frame_done_nb", 32'(frame_done_nb), 32'd0);
    tick();
    reset      = 1'b0;
    load_valid = 1'b0;
    t2 = frames + 1;
    push(t2, {7'h00, 7'h00, 7'h00, 7'h3F}, {4{7'h3F}}, 4'b0000);
    tick();
    check("no_accept_in_reset", 32'(load_ready), 32'd1);
    wait_frame(t2 + 1);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
